// File: rtl/pe_pkg.sv
// Shared definitions for the priority-encoder link receive side:
// default sizes, the frame FSM state type and a reference code decoder.
package pe_pkg;

    localparam int N_REQ  = 3;
    localparam int CODE_W = 2;
    localparam int CNT_W  = 4;

    // Widest one-hot vector a CODE_W-bit code can address.
    localparam int DEC_W  = 2 ** CODE_W;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEC_W-1:0] onehot;
        logic             range_err;
    } dec_t;

    // Code k (1..n) maps to line k-1; code 0 maps to nothing; codes above n
    // map to nothing and raise the range flag.
    function automatic dec_t pe_decode(input logic [CODE_W-1:0] code,
                                       input int unsigned       n);
        dec_t r;
        r.onehot    = '0;
        r.range_err = (int'(code) > int'(n));
        if (code != '0 && !r.range_err) begin
            r.onehot[code - 1'b1] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_code_dec.sv
// Combinational code-to-one-hot decoder with out-of-range flag.
// Code 0 and codes above N both decode to an all-zero vector.
module pe_code_dec #(
    parameter int N      = 3,
    parameter int CODE_W = 2
) (
    input  logic [CODE_W-1:0] code,
    output logic [N-1:0]      onehot,
    output logic              range_err
);

    localparam logic [CODE_W-1:0] N_CODE = CODE_W'(N);

    // Decode one code into its request line and flag codes beyond N.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        onehot    = '0;
        range_err = (code > N_CODE);
        for (int i = 0; i < N; i++) begin
            if (code == CODE_W'(i + 1)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_frame_decoder.sv
// Frame decoder: ORs decoded request codes over a frame and presents the
// rebuilt vector, beat count and error flag on a registered handshake.
// Optional build macro PE_FRAME_ORDER_CHECK_EN adds a highest-first
// ordering check reported on out_order_err.
module pe_frame_decoder #(
    parameter int N      = pe_pkg::N_REQ,
    parameter int CODE_W = pe_pkg::CODE_W,
    parameter int CNT_W  = pe_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_vec,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_err,
    output logic              out_order_err
);

    import pe_pkg::*;

    state_t            state;
    logic [N-1:0]      acc;
    logic [CNT_W-1:0]  cnt;
    logic              err;

    logic [N-1:0]      dec;
    logic              range_err;
    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;

    pe_code_dec #(
        .N      (N),
        .CODE_W (CODE_W)
    ) u_code_dec (
        .code      (in_code),
        .onehot    (dec),
        .range_err (range_err)
    );

    // Handshake flags are straight decodes of the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    // Beat counter holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    // Frame FSM: accumulate beats in ACCUM, publish on the last beat, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            out_vec <= '0;
            out_cnt <= '0;
            out_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_vec <= acc | dec;
                            out_cnt <= cnt_inc;
                            out_err <= err | range_err;
                            acc     <= '0;
                            cnt     <= '0;
                            err     <= 1'b0;
                            state   <= HOLD;
                        end else begin
                            acc <= acc | dec;
                            cnt <= cnt_inc;
                            err <= err | range_err;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef PE_FRAME_ORDER_CHECK_EN
    logic [CODE_W-1:0] last_code;
    logic              order_flag;
    logic              order_viol;
    logic              order_err_q;
    logic              code_live;

    // Only nonzero in-range codes take part in the ordering check.
    assign code_live  = (in_code != '0) && !range_err;
    assign order_viol = accept && code_live && (last_code != '0) && (in_code >= last_code);

    // Track the previous live code; a code not strictly below it breaks highest-first order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_code   <= '0;
            order_flag  <= 1'b0;
            order_err_q <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                order_err_q <= order_flag | order_viol;
                last_code   <= '0;
                order_flag  <= 1'b0;
            end else begin
                order_flag <= order_flag | order_viol;
                if (code_live) begin
                    last_code <= in_code;
                end
            end
        end
    end

    assign out_order_err = order_err_q;
`else
    assign out_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_frame_decoder.sv
// Directed bench for pe_frame_decoder: default N=3 instance plus an N=2
// instance for the out-of-range code case.
module tb_pe_frame_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_valid2;
    logic [1:0] in_code;
    logic       in_last;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_vec;
    logic [3:0] out_cnt;
    logic       out_err;
    logic       out_order_err;

    logic       in_ready2;
    logic       out_valid2;
    logic [1:0] out_vec2;
    logic [3:0] out_cnt2;
    logic       out_err2;
    logic       out_order_err2;

    int passed = 0;
    int total  = 0;
    logic exp_order;

    always #5 clk = ~clk;

    pe_frame_decoder #(.N(3), .CODE_W(2), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vec       (out_vec),
        .out_cnt       (out_cnt),
        .out_err       (out_err),
        .out_order_err (out_order_err)
    );

    pe_frame_decoder #(.N(2), .CODE_W(2), .CNT_W(4)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid2),
        .in_ready      (in_ready2),
        .in_code       (in_code),
        .in_last       (in_last),
        .out_valid     (out_valid2),
        .out_ready     (out_ready),
        .out_vec       (out_vec2),
        .out_cnt       (out_cnt2),
        .out_err       (out_err2),
        .out_order_err (out_order_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one beat on the selected instance; waits (bounded) for in_ready.
    task automatic send(input bit to2, input logic [1:0] code, input logic last);
        int waited = 0;
        @(negedge clk);
        while (!(to2 ? in_ready2 : in_ready) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("beat_ready", to2 ? in_ready2 : in_ready, 1);
        if (last) chk("valid_before_last", to2 ? out_valid2 : out_valid, 0);
        in_code = code;
        in_last = last;
        if (to2) in_valid2 = 1'b1;
        else     in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [2:0] v,
                                 input logic [3:0] c, input logic e);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_vec"},   out_vec,   v);
        chk({tag, "_cnt"},   out_cnt,   c);
        chk({tag, "_err"},   out_err,   e);
    endtask

    // One clock after a result with out_ready=1 the block is back in ACCUM.
    task automatic expect_release(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_rel_valid"}, out_valid, 0);
        chk({tag, "_rel_ready"}, in_ready,  1);
    endtask

    initial begin
`ifdef PE_FRAME_ORDER_CHECK_EN
        exp_order = 1'b1;
`else
        exp_order = 1'b0;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_code   = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,      1);
        chk("rst_out_valid", out_valid,     0);
        chk("rst_order_err", out_order_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 3,1 -> 101, two beats
        send(0, 2'd3, 0);
        send(0, 2'd1, 1);
        expect_result("f31", 3'b101, 4'd2, 0);
        expect_release("f31");

        // Single-beat frames: code 2, then code 0
        send(0, 2'd2, 1);
        expect_result("single2", 3'b010, 4'd1, 0);
        expect_release("single2");
        send(0, 2'd0, 1);
        expect_result("single0", 3'b000, 4'd1, 0);
        expect_release("single0");

        // Frame 2,3 held for 5 cycles with a beat offered during HOLD
        out_ready = 1'b0;
        send(0, 2'd2, 0);
        send(0, 2'd3, 1);
        expect_result("hold", 3'b110, 4'd2, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_code  = 2'd1;
            in_last  = 1'b1;
            chk("hold_in_ready",  in_ready,  0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_vec",       out_vec,   3'b110);
            chk("hold_cnt",       out_cnt,   4'd2);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        expect_release("hold");

        // 20 beats of code 1, then a last beat of code 1 -> saturated count
        for (int i = 0; i < 20; i++) send(0, 2'd1, 0);
        send(0, 2'd1, 1);
        expect_result("sat", 3'b001, 4'd15, 0);
        expect_release("sat");

        // N=2 instance: code 3 out of range, then 1 last; then a clean frame
        send(1, 2'd3, 0);
        send(1, 2'd1, 1);
        chk("range_valid", out_valid2, 1);
        chk("range_vec",   out_vec2,   2'b01);
        chk("range_cnt",   out_cnt2,   4'd2);
        chk("range_err",   out_err2,   1);
        send(1, 2'd2, 1);
        chk("clean_valid", out_valid2, 1);
        chk("clean_vec",   out_vec2,   2'b10);
        chk("clean_err",   out_err2,   0);

        // Reset mid-frame after codes 3,2 discards the partial frame
        send(0, 2'd3, 0);
        send(0, 2'd2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 2'd1, 1);
        expect_result("after_rst", 3'b001, 4'd1, 0);
        expect_release("after_rst");

        // Reset during HOLD drops out_valid without a clock edge
        out_ready = 1'b0;
        send(0, 2'd2, 1);
        chk("holdrst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("holdrst_valid", out_valid, 0);
        chk("holdrst_ready", in_ready,  1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Ordering: 1 then 3 breaks highest-first; 3 then 1 is fine
        send(0, 2'd1, 0);
        send(0, 2'd3, 1);
        expect_result("ord13", 3'b101, 4'd2, 0);
        chk("ord13_order", out_order_err, exp_order);
        expect_release("ord13");
        send(0, 2'd3, 0);
        send(0, 2'd1, 1);
        expect_result("ord31", 3'b101, 4'd2, 0);
        chk("ord31_order", out_order_err, 0);
        expect_release("ord31");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
